// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the core and the RV32M multiply/divide unit.
// Handshake: start is taken only while busy is low; busy then stays high until the
// one-cycle done/write_en pulse, which carries result and rd_out for the register file.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        write_en;
    logic [4:0]  rd_out;
    logic [31:0] result;
    logic [1:0]  state_dbg;

    modport master (
        output start, funct3, operand_a, operand_b, rd_in,
        input  busy, done, write_en, rd_out, result, state_dbg
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, rd_in,
        output busy, done, write_en, rd_out, result, state_dbg
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, fixed 33-cycle latency for every op.
// Define MULDIV_DIV_EN to build the divider; without it divide ops complete with result 0.
module muldiv_unit (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opd_q, opd_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
`ifdef MULDIV_DIV_EN
    logic [31:0] a_raw_q, a_raw_d;
    logic        b_zero_q, b_zero_d;
    logic        ovf_q, ovf_d;
`endif

    logic        sgn_a, sgn_b, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        sgn_a = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
        sgn_b = sgn_a && (bus.funct3 != 3'b010);
        neg_a = sgn_a & bus.operand_a[31];
        neg_b = sgn_b & bus.operand_b[31];
        mag_a = neg_a ? (~bus.operand_a + 32'd1) : bus.operand_a;
        mag_b = neg_b ? (~bus.operand_b + 32'd1) : bus.operand_b;
    end

    // Multiply: {hi,lo} starts as {0, multiplier}; add multiplicand into hi, shift right.
    logic [32:0] mul_sum;
    logic [31:0] mul_hi, mul_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : 33'd0);
        mul_hi  = mul_sum[32:1];
        mul_lo  = {mul_sum[0], lo_q[31:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [31:0] div_hi, div_lo;

    always_comb begin
        div_shift = {hi_q, lo_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
        if (!div_diff[33]) begin
            div_hi = div_diff[31:0];
            div_lo = {lo_q[30:0], 1'b1};
        end else begin
            div_hi = div_shift[31:0];
            div_lo = {lo_q[30:0], 1'b0};
        end
    end
`endif

    logic [31:0] step_hi, step_lo, final_res;
    logic [63:0] prod, prod_s;
`ifdef MULDIV_DIV_EN
    logic [31:0] quot, rem;
`endif

    // final_res is formed from the last iteration's next values so it lands in DONE.
    always_comb begin
        step_hi   = mul_hi;
        step_lo   = mul_lo;
        prod      = {mul_hi, mul_lo};
        prod_s    = neg_q ? (~prod + 64'd1) : prod;
        final_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
`ifdef MULDIV_DIV_EN
        quot = neg_q ? (~div_lo + 32'd1) : div_lo;
        rem  = rem_neg_q ? (~div_hi + 32'd1) : div_hi;
        if (op_q[2]) begin
            step_hi = div_hi;
            step_lo = div_lo;
            if (op_q[1]) begin
                final_res = b_zero_q ? a_raw_q : (ovf_q ? 32'd0 : rem);
            end else begin
                final_res = b_zero_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quot);
            end
        end
`else
        if (op_q[2]) begin
            final_res = 32'd0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opd_d     = opd_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        a_raw_d   = a_raw_q;
        b_zero_d  = b_zero_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_CALC;
                    cnt_d     = 6'd0;
                    op_d      = bus.funct3;
                    rd_d      = bus.rd_in;
                    hi_d      = 32'd0;
                    lo_d      = bus.funct3[2] ? mag_a : mag_b;
                    opd_d     = bus.funct3[2] ? mag_b : mag_a;
                    neg_d     = neg_a ^ neg_b;
                    rem_neg_d = neg_a;
`ifdef MULDIV_DIV_EN
                    a_raw_d   = bus.operand_a;
                    b_zero_d  = (bus.operand_b == 32'd0);
                    ovf_d     = !bus.funct3[0] && (bus.operand_a == 32'h8000_0000) &&
                                (bus.operand_b == 32'hFFFF_FFFF);
`endif
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            opd_q     <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            a_raw_q   <= 32'd0;
            b_zero_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opd_q     <= opd_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            done_q    <= done_d;
`ifdef MULDIV_DIV_EN
            a_raw_q   <= a_raw_d;
            b_zero_q  <= b_zero_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.write_en  = done_q;
    assign bus.rd_out    = rd_q;
    assign bus.result    = result_q;
    assign bus.state_dbg = state_q;
endmodule
